ysyx_22050598_ifu_fetch: RTL



---
 rtl/ysyx_22050598_ifu_defs_pkg.sv | 14 +
 rtl/ysyx_22050598_ifu_pc_reg.sv | 43 ++++
 rtl/ysyx_22050598_ifu_fetch.sv | 96 +++++++++
 3 files changed

// File: rtl/ysyx_22050598_ifu_defs_pkg.sv
// Shared state encodings and constants for the IFU fetch front end.
package ysyx_22050598_ifu_defs;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          IFU_INST_W   = 32;
    localparam logic [63:0] IFU_PC_INC   = 64'd4;

endpackage

// File: rtl/ysyx_22050598_ifu_pc_reg.sv
// Architectural fetch PC: reset > redirect > consume(+4) > hold.
// Optional target alignment / misalign flag under YSYX_22050598_IFU_MISALIGN_EN.
module ysyx_22050598_ifu_pc_reg
    import ysyx_22050598_ifu_defs::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [63:0] target,
    input  logic        consume,
    output logic [63:0] pc_q,
    output logic        misalign_q
);

    logic [63:0] target_aligned;
    logic        misalign_next;

`ifdef YSYX_22050598_IFU_MISALIGN_EN
    assign target_aligned = {target[63:2], 2'b00};
    assign misalign_next  = redirect & (target[1:0] != 2'b00);
`else
    assign target_aligned = target;
    assign misalign_next  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            // The flag is a one-cycle pulse following the offending redirect.
            misalign_q <= misalign_next;
            if (redirect) begin
                pc_q <= target_aligned;
            end else if (consume) begin
                pc_q <= pc_q + IFU_PC_INC;
            end
        end
    end

endmodule

// File: rtl/ysyx_22050598_ifu_fetch.sv
// IFU fetch front end: one outstanding imem request, redirect squash, IDU handshake.
// Optional misalign handling is enabled by defining YSYX_22050598_IFU_MISALIGN_EN.
module ysyx_22050598_ifu_fetch
    import ysyx_22050598_ifu_defs::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          INST_W   = IFU_INST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_pc_data_ena_i,
    input  logic [63:0]       ex_pc_data_i,
    output logic              if_req_valid_o,
    input  logic              if_req_ready_i,
    output logic [63:0]       if_req_addr_o,
    input  logic              if_rsp_valid_i,
    input  logic [INST_W-1:0] if_rsp_data_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [63:0]       id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              fetch_misalign_o
);

    ifu_state_e        state_q;
    logic [63:0]       pc_q;
    logic [63:0]       inflight_pc_q;
    logic              kill_q;
    logic [INST_W-1:0] inst_q;
    logic              consume;

    // A redirect in HOLD squashes the presented instruction combinationally.
    assign id_valid_o = (state_q == IFU_HOLD) & ~ex_pc_data_ena_i;
    assign consume    = id_valid_o & id_ready_i;

    assign if_req_valid_o = (state_q == IFU_REQ);
    assign if_req_addr_o  = pc_q;
    assign id_pc_o        = inflight_pc_q;
    assign id_inst_o      = inst_q;

    ysyx_22050598_ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (ex_pc_data_ena_i),
        .target     (ex_pc_data_i),
        .consume    (consume),
        .pc_q       (pc_q),
        .misalign_q (fetch_misalign_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IFU_REQ;
            kill_q        <= 1'b0;
            inst_q        <= '0;
            inflight_pc_q <= '0;
        end else begin
            case (state_q)
                IFU_REQ: begin
                    if (if_req_ready_i) begin
                        inflight_pc_q <= pc_q;
                        state_q       <= IFU_WAIT;
                        // Accepted request already targets the wrong path.
                        if (ex_pc_data_ena_i) begin
                            kill_q <= 1'b1;
                        end
                    end
                end
                IFU_WAIT: begin
                    if (if_rsp_valid_i) begin
                        if (!kill_q && !ex_pc_data_ena_i) begin
                            inst_q  <= if_rsp_data_i;
                            state_q <= IFU_HOLD;
                        end else begin
                            kill_q  <= 1'b0;
                            state_q <= IFU_REQ;
                        end
                    end else if (ex_pc_data_ena_i) begin
                        kill_q <= 1'b1;
                    end
                end
                IFU_HOLD: begin
                    if (ex_pc_data_ena_i || id_ready_i) begin
                        state_q <= IFU_REQ;
                    end
                end
                default: begin
                    state_q <= IFU_REQ;
                end
            endcase
        end
    end

endmodule
